// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624 frame controller: frame width, FSM state
// encoding, command/address constants and the frame packing helper.
package dac_pkg;

    localparam int unsigned FRAME_W = 32;

    localparam logic [3:0] CMD_WR_UPD = 4'h3;
    localparam logic [3:0] CMD_PWR_DN = 4'h4;
    localparam logic [3:0] ADDR_ALL   = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } dac_state_e;

    // 8 don't-care bits, command, address, 12-bit code, 4 don't-care bits
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] data
    );
        return {8'h00, cmd, addr, data, 4'h0};
    endfunction

endpackage

// File: rtl/dac_frame_ctrl_if.sv
// Request/status and serial-pin bundle of dac_frame_ctrl; master drives
// requests and the DAC echo, slave is the frame controller side.
interface dac_frame_ctrl_if;

    logic        START;
    logic [3:0]  CMD;
    logic [3:0]  ADDR;
    logic [11:0] DATA;
    logic        BUSY;
    logic        DONE;
    logic        SPI_SCK;
    logic        SPI_MOSI;
    logic        DAC_CS;
    logic        DAC_CLR;
    logic        DAC_OUT;
    logic        ECHO_ERR;

    modport master (
        output START, CMD, ADDR, DATA, DAC_OUT,
        input  BUSY, DONE, SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, ECHO_ERR
    );

    modport slave (
        input  START, CMD, ADDR, DATA, DAC_OUT,
        output BUSY, DONE, SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, ECHO_ERR
    );

endinterface

// File: rtl/dac_sck_tick.sv
// Half-period tick generator: pulses tick_o every CLK_DIV enabled cycles;
// clear_i restarts the count so the first tick lands CLK_DIV cycles later.
module dac_sck_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == 8'(CLK_DIV - 1)) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_frame_ctrl.sv
// LTC2624 32-bit SPI frame controller (IDLE->SETUP->SHIFT->HOLD->GAP).
// Define DAC_ECHO_CHECK_EN to build the SDO echo comparison and ECHO_ERR flag.
module dac_frame_ctrl
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        START,
    input  logic [3:0]  CMD,
    input  logic [3:0]  ADDR,
    input  logic [11:0] DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    input  logic        DAC_OUT,
    output logic        ECHO_ERR
);

    dac_state_e          state_q, state_d;
    logic                sck_q, sck_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [5:0]          hp_q, hp_d;
    logic                done_q, done_d;
    logic                start_acc;
    logic                tick;

    assign start_acc = START && (state_q == IDLE);

    dac_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i    (CLK50MHZ),
        .rst_i    (RST),
        .clear_i  (start_acc),
        .enable_i (state_q != IDLE),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        shift_d = shift_q;
        hp_d    = hp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    shift_d = build_frame(CMD, ADDR, DATA);
                    sck_d   = 1'b0;
                    hp_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // even half-periods are SCK high; MOSI advances on each falling edge
                if (tick) begin
                    hp_d = hp_q + 6'd1;
                    if (hp_q == 6'd63) begin
                        sck_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        sck_d = ~sck_q;
                        if (sck_q) begin
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sck_q   <= 1'b0;
            shift_q <= '0;
            hp_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            shift_q <= shift_d;
            hp_q    <= hp_d;
            done_q  <= done_d;
        end
    end

    assign BUSY     = (state_q != IDLE);
    assign DONE     = done_q;
    assign SPI_SCK  = sck_q;
    assign DAC_CS   = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
    assign SPI_MOSI = !DAC_CS && shift_q[FRAME_W-1];
    assign DAC_CLR  = !RST;

`ifdef DAC_ECHO_CHECK_EN
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] prev_q;
    logic [FRAME_W-1:0] echo_q;
    logic               prev_vld_q;
    logic               err_q;

    // RST is the only abort path, so clearing prev_vld_q covers both skip cases
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            frame_q    <= '0;
            prev_q     <= '0;
            echo_q     <= '0;
            prev_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                frame_q <= build_frame(CMD, ADDR, DATA);
            end
            if (sck_d && !sck_q) begin
                echo_q <= {echo_q[FRAME_W-2:0], DAC_OUT};
            end
            if (tick && (state_q == HOLD)) begin
                if (prev_vld_q && (echo_q != prev_q)) begin
                    err_q <= 1'b1;
                end
                prev_q     <= frame_q;
                prev_vld_q <= 1'b1;
            end
        end
    end

    assign ECHO_ERR = err_q;
`else
    logic unused_dac_out;
    assign unused_dac_out = DAC_OUT;
    assign ECHO_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Directed bench for dac_frame_ctrl at CLK_DIV 1, 2 and 5; sel picks the
// instance that receives START and whose pins are observed.
module tb_dac_frame_ctrl;
    import dac_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_r;
    logic [3:0]  cmd_r;
    logic [3:0]  addr_r;
    logic [11:0] data_r;
    logic        dout_r;
    int          sel;

    int vectors;
    int miscompares;

    logic o_busy, o_done, o_sck, o_mosi, o_cs, o_clr, o_err;

    logic [31:0] r_fr;
    int r_rises, r_done_k, r_ndone, r_cs_low_k, r_cs_high_k, r_gap_hi;
    int r_hi_min, r_hi_max, r_lo_min, r_lo_max;
    logic r_busy1, r_busy_at_done;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    dac_frame_ctrl_if b1 ();
    dac_frame_ctrl_if b2 ();
    dac_frame_ctrl_if b5 ();

    assign b1.START = start_r && (sel == 1);
    assign b2.START = start_r && (sel == 2);
    assign b5.START = start_r && (sel == 5);
    assign b1.CMD = cmd_r;    assign b2.CMD = cmd_r;    assign b5.CMD = cmd_r;
    assign b1.ADDR = addr_r;  assign b2.ADDR = addr_r;  assign b5.ADDR = addr_r;
    assign b1.DATA = data_r;  assign b2.DATA = data_r;  assign b5.DATA = data_r;
    assign b1.DAC_OUT = dout_r; assign b2.DAC_OUT = dout_r; assign b5.DAC_OUT = dout_r;

    dac_frame_ctrl #(.CLK_DIV(1)) u_d1 (
        .CLK50MHZ(clk), .RST(rst), .START(b1.START), .CMD(b1.CMD), .ADDR(b1.ADDR),
        .DATA(b1.DATA), .BUSY(b1.BUSY), .DONE(b1.DONE), .SPI_SCK(b1.SPI_SCK),
        .SPI_MOSI(b1.SPI_MOSI), .DAC_CS(b1.DAC_CS), .DAC_CLR(b1.DAC_CLR),
        .DAC_OUT(b1.DAC_OUT), .ECHO_ERR(b1.ECHO_ERR)
    );

    dac_frame_ctrl #(.CLK_DIV(2)) u_d2 (
        .CLK50MHZ(clk), .RST(rst), .START(b2.START), .CMD(b2.CMD), .ADDR(b2.ADDR),
        .DATA(b2.DATA), .BUSY(b2.BUSY), .DONE(b2.DONE), .SPI_SCK(b2.SPI_SCK),
        .SPI_MOSI(b2.SPI_MOSI), .DAC_CS(b2.DAC_CS), .DAC_CLR(b2.DAC_CLR),
        .DAC_OUT(b2.DAC_OUT), .ECHO_ERR(b2.ECHO_ERR)
    );

    dac_frame_ctrl #(.CLK_DIV(5)) u_d5 (
        .CLK50MHZ(clk), .RST(rst), .START(b5.START), .CMD(b5.CMD), .ADDR(b5.ADDR),
        .DATA(b5.DATA), .BUSY(b5.BUSY), .DONE(b5.DONE), .SPI_SCK(b5.SPI_SCK),
        .SPI_MOSI(b5.SPI_MOSI), .DAC_CS(b5.DAC_CS), .DAC_CLR(b5.DAC_CLR),
        .DAC_OUT(b5.DAC_OUT), .ECHO_ERR(b5.ECHO_ERR)
    );

    always_comb begin
        case (sel)
            1: begin
                o_busy = b1.BUSY; o_done = b1.DONE; o_sck = b1.SPI_SCK; o_mosi = b1.SPI_MOSI;
                o_cs = b1.DAC_CS; o_clr = b1.DAC_CLR; o_err = b1.ECHO_ERR;
            end
            5: begin
                o_busy = b5.BUSY; o_done = b5.DONE; o_sck = b5.SPI_SCK; o_mosi = b5.SPI_MOSI;
                o_cs = b5.DAC_CS; o_clr = b5.DAC_CLR; o_err = b5.ECHO_ERR;
            end
            default: begin
                o_busy = b2.BUSY; o_done = b2.DONE; o_sck = b2.SPI_SCK; o_mosi = b2.SPI_MOSI;
                o_cs = b2.DAC_CS; o_clr = b2.DAC_CLR; o_err = b2.ECHO_ERR;
            end
        endcase
    end

    // Called just after a falling clock edge: START is raised now, so the next
    // rising edge is acceptance cycle n and sample k is taken in cycle n+k.
    task automatic run_frame(input int len, input logic [3:0] c, input logic [3:0] a,
                             input logic [11:0] d, input logic [31:0] echo,
                             input int extra_k, input int dchg_k, input bit chain);
        logic prev_sck;
        int   hi_run;
        int   lo_run;
        int   falls;
        bit   seen_rise;
        r_fr = '0; r_rises = 0; r_done_k = 0; r_ndone = 0; r_cs_low_k = 0; r_cs_high_k = 0;
        r_gap_hi = 0; r_hi_min = 1000; r_hi_max = 0; r_lo_min = 1000; r_lo_max = 0;
        r_busy1 = 1'b0; r_busy_at_done = 1'b1;
        prev_sck = 1'b0; hi_run = 0; lo_run = 0; falls = 0; seen_rise = 1'b0;
        start_r = 1'b1; cmd_r = c; addr_r = a; data_r = d; dout_r = echo[31];
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1 || (extra_k > 0 && k == extra_k + 1)) start_r = 1'b0;
            if (extra_k > 0 && k == extra_k) start_r = 1'b1;
            if (k == dchg_k) data_r = ~d;
            if (k == 1) r_busy1 = o_busy;
            if (o_sck && !prev_sck) begin
                r_rises++;
                r_fr = {r_fr[30:0], o_mosi};
                if (seen_rise) begin
                    if (lo_run < r_lo_min) r_lo_min = lo_run;
                    if (lo_run > r_lo_max) r_lo_max = lo_run;
                end
                seen_rise = 1'b1;
                hi_run = 0;
            end
            if (!o_sck && prev_sck) begin
                falls++;
                if (hi_run < r_hi_min) r_hi_min = hi_run;
                if (hi_run > r_hi_max) r_hi_max = hi_run;
                lo_run = 0;
            end
            if (o_sck) hi_run++; else lo_run++;
            dout_r = (falls < 32) ? echo[5'(31 - falls)] : 1'b0;
            if (!o_cs && r_cs_low_k == 0) r_cs_low_k = k;
            if (o_cs && r_cs_low_k != 0 && r_cs_high_k == 0) r_cs_high_k = k;
            if (o_cs && o_busy) r_gap_hi++;
            if (o_done) begin
                r_ndone++;
                if (r_done_k == 0) begin
                    r_done_k = k;
                    r_busy_at_done = o_busy;
                end
                if (chain) break;
            end
            prev_sck = o_sck;
        end
    endtask

    task automatic test_reset;
        sel = 2; rst = 1'b1; start_r = 1'b0; cmd_r = '0; addr_r = '0; data_r = '0; dout_r = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (o_cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs got=%b exp=1", o_cs); end
        vectors++; if (o_sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck got=%b exp=0", o_sck); end
        vectors++; if (o_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi got=%b exp=0", o_mosi); end
        vectors++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got=%b%b exp=00", o_busy, o_done); end
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", o_err); end
        vectors++; if (o_clr !== 1'b0) begin miscompares++; $display("FAIL reset_clr got=%b exp=0", o_clr); end
        vectors++; if ({b1.DAC_CS, b5.DAC_CS} !== 2'b11) begin miscompares++; $display("FAIL reset_cs_others got=%b exp=11", {b1.DAC_CS, b5.DAC_CS}); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (o_clr !== 1'b1) begin miscompares++; $display("FAIL run_clr got=%b exp=1", o_clr); end
        vectors++; if (o_cs !== 1'b1 || o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_cs_busy got=%b%b exp=10", o_cs, o_busy); end
    endtask

    task automatic test_basic_frame;
        sel = 2;
        run_frame(140, CMD_WR_UPD, 4'h0, 12'hABC, '0, 0, 0, 1'b0);
        vectors++; if (r_fr !== 32'h0030ABC0) begin miscompares++; $display("FAIL basic_frame got=%h exp=0030abc0", r_fr); end
        vectors++; if (r_rises !== 32) begin miscompares++; $display("FAIL basic_rises got=%0d exp=32", r_rises); end
        vectors++; if (r_done_k !== 135 || r_ndone !== 1) begin miscompares++; $display("FAIL basic_done got=%0d/%0d exp=135/1", r_done_k, r_ndone); end
        vectors++; if (r_cs_low_k !== 1 || r_busy1 !== 1'b1) begin miscompares++; $display("FAIL basic_cs_busy_start got=%0d/%b exp=1/1", r_cs_low_k, r_busy1); end
        vectors++; if (r_cs_high_k !== 133) begin miscompares++; $display("FAIL basic_cs_rise got=%0d exp=133", r_cs_high_k); end
        vectors++; if (r_busy_at_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done got=%b exp=0", r_busy_at_done); end
        vectors++; if (r_hi_min !== 2 || r_hi_max !== 2 || r_lo_min !== 2 || r_lo_max !== 2) begin miscompares++; $display("FAIL basic_sck_width got=%0d,%0d,%0d,%0d exp=2,2,2,2", r_hi_min, r_hi_max, r_lo_min, r_lo_max); end
        vectors++; if (o_cs !== 1'b1 || o_mosi !== 1'b0 || o_sck !== 1'b0) begin miscompares++; $display("FAIL basic_idle_pins got=%b%b%b exp=100", o_cs, o_mosi, o_sck); end
    endtask

    task automatic test_busy_ignore;
        sel = 2;
        run_frame(250, CMD_WR_UPD, ADDR_ALL, 12'h5A5, '0, 10, 20, 1'b0);
        vectors++; if (r_fr !== 32'h003F5A50) begin miscompares++; $display("FAIL busy_frame got=%h exp=003f5a50", r_fr); end
        vectors++; if (r_ndone !== 1 || r_done_k !== 135) begin miscompares++; $display("FAIL busy_one_done got=%0d@%0d exp=1@135", r_ndone, r_done_k); end
        vectors++; if (r_rises !== 32) begin miscompares++; $display("FAIL busy_rises got=%0d exp=32", r_rises); end
    endtask

    task automatic test_back_to_back;
        sel = 2;
        run_frame(200, CMD_PWR_DN, 4'h1, 12'h800, '0, 0, 0, 1'b1);
        vectors++; if (r_fr !== 32'h00418000 || r_done_k !== 135) begin miscompares++; $display("FAIL b2b_first got=%h@%0d exp=00418000@135", r_fr, r_done_k); end
        vectors++; if (r_gap_hi !== 2) begin miscompares++; $display("FAIL b2b_gap_cs_high got=%0d exp=2", r_gap_hi); end
        run_frame(140, CMD_WR_UPD, 4'h2, 12'h00F, '0, 0, 0, 1'b0);
        vectors++; if (r_cs_low_k !== 1) begin miscompares++; $display("FAIL b2b_second_cs got=%0d exp=1", r_cs_low_k); end
        vectors++; if (r_fr !== 32'h003200F0 || r_done_k !== 135) begin miscompares++; $display("FAIL b2b_second got=%h@%0d exp=003200f0@135", r_fr, r_done_k); end
    endtask

    task automatic test_reset_abort;
        int nd;
        sel = 2;
        start_r = 1'b1; cmd_r = 4'h3; addr_r = 4'h0; data_r = 12'h555;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start_r = 1'b0;
        end
        vectors++; if (o_sck !== 1'b1 || o_cs !== 1'b0) begin miscompares++; $display("FAIL abort_pre got=%b%b exp=10", o_sck, o_cs); end
        rst = 1'b1;
        #1;
        vectors++; if (o_cs !== 1'b1 || o_sck !== 1'b0) begin miscompares++; $display("FAIL abort_pins got=%b%b exp=10", o_cs, o_sck); end
        vectors++; if (o_busy !== 1'b0 || o_mosi !== 1'b0 || o_clr !== 1'b0) begin miscompares++; $display("FAIL abort_busy_mosi_clr got=%b%b%b exp=000", o_busy, o_mosi, o_clr); end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        vectors++; if (nd !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
        run_frame(140, 4'h3, 4'h4, 12'h7E1, '0, 0, 0, 1'b0);
        vectors++; if (r_fr !== 32'h00347E10 || r_done_k !== 135) begin miscompares++; $display("FAIL abort_next got=%h@%0d exp=00347e10@135", r_fr, r_done_k); end
    endtask

    task automatic test_clk_div;
        int          dv   [4] = '{1, 1, 5, 5};
        logic [11:0] dat  [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
        logic [31:0] efr  [4] = '{32'h00300000, 32'h0030FFF0, 32'h00300000, 32'h0030FFF0};
        int          edone[4] = '{68, 68, 336, 336};
        int          ecsh [4] = '{67, 67, 331, 331};
        for (int i = 0; i < 4; i++) begin
            sel = dv[i];
            run_frame(edone[i] + 5, 4'h3, 4'h0, dat[i], '0, 0, 0, 1'b0);
            vectors++; if (r_fr !== efr[i] || r_rises !== 32) begin miscompares++; $display("FAIL div%0d_frame got=%h/%0d exp=%h/32", dv[i], r_fr, r_rises, efr[i]); end
            vectors++; if (r_done_k !== edone[i] || r_cs_high_k !== ecsh[i]) begin miscompares++; $display("FAIL div%0d_timing got=%0d/%0d exp=%0d/%0d", dv[i], r_done_k, r_cs_high_k, edone[i], ecsh[i]); end
            vectors++; if (r_hi_min !== dv[i] || r_hi_max !== dv[i] || r_lo_min !== dv[i] || r_lo_max !== dv[i]) begin miscompares++; $display("FAIL div%0d_sck_width got=%0d,%0d,%0d,%0d exp=%0d", dv[i], r_hi_min, r_hi_max, r_lo_min, r_lo_max, dv[i]); end
        end
    endtask

    task automatic test_echo;
        sel = 2;
`ifdef DAC_ECHO_CHECK_EN
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        run_frame(140, 4'h3, 4'h0, 12'h111, 32'hDEADBEEF, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL echo_first_skipped got=%b exp=0", o_err); end
        run_frame(140, 4'h3, 4'h0, 12'h222, 32'h00301110, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL echo_match got=%b exp=0", o_err); end
        run_frame(140, 4'h3, 4'h0, 12'h333, 32'h00303220, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL echo_bit12 got=%b exp=1", o_err); end
        run_frame(140, 4'h3, 4'h0, 12'h444, 32'h00303330, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL echo_sticky got=%b exp=1", o_err); end
        rst = 1'b1;
        #1;
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL echo_reset got=%b exp=0", o_err); end
        @(negedge clk); rst = 1'b0;
`else
        run_frame(140, 4'h3, 4'h0, 12'h111, 32'hFFFFFFFF, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL echo_tied_a got=%b exp=0", o_err); end
        run_frame(140, 4'h3, 4'h0, 12'h222, 32'h5A5A5A5A, 0, 0, 1'b0);
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL echo_tied_b got=%b exp=0", o_err); end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_frame();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_clk_div();
        test_echo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
